i2c_slave_reg: RTL and testbench

I2C_SLAVE_REG -- requirements
Module: i2c_slave_reg

---
 rtl/i2c_slave_reg.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_slave_reg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_reg.sv
// I2C slave with a small byte-wide register file, oversampled on clk.
// Supports burst writes, current-address reads and sequential reads.
module i2c_slave_reg #(
    parameter logic [6:0]  DEVICE_ADDR    = 7'h50,
    parameter int unsigned MEM_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_scl,
    inout  logic                      io_sda,
    output logic                      o_sda_oe,
    output logic                      o_wr_strobe,
    output logic [7:0]                o_wr_addr,
    output logic [7:0]                o_wr_data,
    output logic                      o_busy,
    input  logic [MEM_DEPTH_LOG2-1:0] i_dbg_addr,
    output logic [7:0]                o_dbg_data
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_DEV_ACK,
        S_REG_ADDR,
        S_REG_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic [7:0] r_mem [MEM_DEPTH];
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_wr_strobe;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;

    logic [MEM_DEPTH_LOG2-1:0] w_ptr_idx;
    logic [7:0]                w_rx_byte;
    logic [7:0]                w_rd_byte;
    logic                      w_addr_match;

    assign io_sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign o_sda_oe    = r_sda_oe;
    assign o_busy      = r_busy;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_dbg_data  = r_mem[i_dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= io_sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // START/STOP need SCL high on both samples so an SDA change that races SCL is not misread
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

    assign w_ptr_idx    = r_ptr[MEM_DEPTH_LOG2-1:0];
    assign w_rx_byte    = {r_shift[6:0], r_sda_s2};
    assign w_rd_byte    = r_mem[w_ptr_idx];
    assign w_addr_match = (r_shift[7:1] == DEVICE_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_DEV_ADDR;
        end else if (w_stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_DEV_ADDR: begin
                    if (w_scl_fall && r_bit_cnt == 4'd8)
                        w_state_next = w_addr_match ? S_DEV_ACK : S_IDLE;
                end
                S_DEV_ACK: begin
                    if (w_scl_fall)
                        w_state_next = r_shift[0] ? S_RD_DATA : S_REG_ADDR;
                end
                S_REG_ADDR: begin
                    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = S_REG_ACK;
                end
                S_REG_ACK: begin
                    if (w_scl_fall) w_state_next = S_WR_DATA;
                end
                S_WR_DATA: begin
                    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = S_WR_ACK;
                end
                S_WR_ACK: begin
                    if (w_scl_fall) w_state_next = S_WR_DATA;
                end
                S_RD_DATA: begin
                    if (w_scl_fall && r_bit_cnt == 4'd8) w_state_next = S_RD_ACK;
                end
                S_RD_ACK: begin
                    if (w_scl_rise && r_sda_s2)
                        w_state_next = S_WAIT_STOP;
                    else if (w_scl_fall && r_bit_cnt == 4'd1)
                        w_state_next = S_RD_DATA;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i[MEM_DEPTH_LOG2-1:0]] <= '0;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_state == S_WR_DATA && r_bit_cnt == 4'd7) begin
                                r_mem[w_ptr_idx] <= w_rx_byte;
                                r_wr_strobe      <= 1'b1;
                                r_wr_addr        <= r_ptr;
                                r_wr_data        <= w_rx_byte;
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= '0;
                            if (r_state == S_DEV_ADDR) begin
                                r_sda_oe <= w_addr_match;
                                r_busy   <= w_addr_match;
                            end else begin
                                r_sda_oe <= 1'b1;
                            end
                            if (r_state == S_REG_ADDR) r_ptr <= r_shift;
                        end
                    end
                    S_DEV_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_shift[0]) begin
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                            end else begin
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_REG_ACK: begin
                        if (w_scl_fall) r_sda_oe <= 1'b0;
                    end
                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_ptr    <= r_ptr + 8'd1;
                        end
                    end
                    S_RD_DATA: begin
                        // r_shift[7] is always the bit on the wire; shift on each fall
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= '0;
                            r_sda_oe  <= 1'b0;
                            r_ptr     <= r_ptr + 8'd1;
                        end else if (w_scl_fall) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise && !r_sda_s2) begin
                            r_bit_cnt <= 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                            r_bit_cnt <= '0;
                            r_shift   <= w_rd_byte;
                            r_sda_oe  <= ~w_rd_byte[7];
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_reg.sv
// Bench for i2c_slave_reg: bit-banged I2C master, byte-level memory model and
// a strobe scoreboard fed from the stimulus side.
module tb_i2c_slave_reg;

    localparam int Q = 6;

    typedef struct {
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] data;
        logic       ack;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_oe;
    wire        sda_bus;
    logic       dut_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_mem [16];
    logic [7:0] m_ptr;
    wr_rec_t    exp_q [$];

    assign sda_bus = m_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave_reg #(.DEVICE_ADDR(7'h50), .MEM_DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl),
        .io_sda     (sda_bus),
        .o_sda_oe   (dut_oe),
        .o_wr_strobe(wr_strobe),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        wr_rec_t e;
        if (wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: actual addr=%0h data=%0h expected no strobe", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                chk("strobe_data", {24'd0, wr_data}, {24'd0, e.data});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; wait_clk(Q);
        scl  = 1'b1; wait_clk(Q);
        m_oe = 1'b1; wait_clk(Q);
        scl  = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; wait_clk(Q);
        scl  = 1'b1; wait_clk(Q);
        m_oe = 1'b0; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        m_oe = ~b; wait_clk(Q);
        scl  = 1'b1; wait_clk(2 * Q);
        scl  = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe9);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_oe = 1'b0; wait_clk(Q);
        scl  = 1'b1; wait_clk(Q);
        ack  = ~sda_bus;
        oe9  = dut_oe;
        wait_clk(Q);
        scl  = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_byte(input logic do_ack, output logic [7:0] d, output logic oe9);
        m_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q); scl = 1'b1;
            wait_clk(Q); d[i] = sda_bus;
            wait_clk(Q); scl = 1'b0;
        end
        m_oe = do_ack;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); oe9 = dut_oe;
        wait_clk(Q); scl = 1'b0;
        wait_clk(Q); m_oe = 1'b0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0];
            #1;
            chk($sformatf("dbg_mem[%0d]", i), {24'd0, dbg_data}, {24'd0, m_mem[i]});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 8'h00;
        exp_q.delete();
    endtask

    task automatic write_txn(input logic [6:0] dev, input logic [7:0] ra, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic exp_ack);
        logic ack, oe9;
        logic [7:0] b;
        bus_start();
        send_byte({dev, 1'b0}, ack, oe9);
        chk("dev_ack", {31'd0, ack}, {31'd0, exp_ack});
        chk("dev_oe9", {31'd0, oe9}, {31'd0, exp_ack});
        chk("busy_after_addr", {31'd0, busy}, {31'd0, exp_ack});
        if (ack) begin
            send_byte(ra, ack, oe9);
            chk("reg_ack", {31'd0, ack}, 32'd1);
            m_ptr = ra;
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? d0 : d1;
                exp_q.push_back('{m_ptr, b});
                m_mem[m_ptr[3:0]] = b;
                m_ptr = m_ptr + 8'd1;
                send_byte(b, ack, oe9);
                chk("data_ack", {31'd0, ack}, 32'd1);
            end
        end
        bus_stop();
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("strobes_drained", exp_q.size(), 32'd0);
    endtask

    task automatic read_txn(input logic set_ptr, input logic [7:0] ra, input int n, input int extra);
        logic ack, oe9;
        logic [7:0] d, e;
        bus_start();
        if (set_ptr) begin
            send_byte(8'hA0, ack, oe9);
            chk("rd_dev_w_ack", {31'd0, ack}, 32'd1);
            send_byte(ra, ack, oe9);
            chk("rd_reg_ack", {31'd0, ack}, 32'd1);
            m_ptr = ra;
            bus_start();
        end
        send_byte(8'hA1, ack, oe9);
        chk("rd_dev_r_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < n; i++) begin
            e = m_mem[m_ptr[3:0]];
            m_ptr = m_ptr + 8'd1;
            recv_byte(i != n - 1, d, oe9);
            chk("rd_data", {24'd0, d}, {24'd0, e});
            chk("rd_9th_released", {31'd0, oe9}, 32'd0);
        end
        for (int k = 0; k < extra; k++) begin
            wait_clk(Q); scl = 1'b1;
            wait_clk(Q);
            chk("wait_stop_released", {31'd0, dut_oe}, 32'd0);
            chk("wait_stop_busy", {31'd0, busy}, 32'd1);
            wait_clk(Q); scl = 1'b0;
        end
        bus_stop();
        chk("rd_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("rd_ptr_after", {24'd0, dut.r_ptr}, {24'd0, m_ptr});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        logic ack, oe9;
        vecs[0] = '{7'h50, 8'h23, 8'h45, 1'b1};
        vecs[1] = '{7'h51, 8'h23, 8'h99, 1'b0};
        vecs[2] = '{7'h50, 8'h05, 8'hA5, 1'b1};
        vecs[3] = '{7'h28, 8'h06, 8'h11, 1'b0};
        vecs[4] = '{7'h50, 8'h1C, 8'h3C, 1'b1};
        vecs[5] = '{7'h50, 8'h81, 8'h7E, 1'b1};
        vecs[6] = '{7'h10, 8'h08, 8'h55, 1'b0};

        rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0; dbg_addr = '0;
        model_reset();
        wait_clk(3);
        chk("rst_oe", {31'd0, dut_oe}, 32'd0);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        check_mem();
        rst_n = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 7; i++) begin
            write_txn(vecs[i].dev, vecs[i].ra, 1, vecs[i].data, 8'h00, vecs[i].ack);
        end
        check_mem();

        // random read of 0x23 then pointer check
        read_txn(1'b1, 8'h23, 1, 0);

        // burst across the memory wrap and pointer wrap at 0xFF
        write_txn(7'h50, 8'h0F, 2, 8'hAA, 8'hBB, 1'b1);
        write_txn(7'h50, 8'hFF, 1, 8'h11, 8'h00, 1'b1);
        chk("ptr_wrap_one", {24'd0, dut.r_ptr}, {24'd0, m_ptr});
        write_txn(7'h50, 8'hFF, 2, 8'h22, 8'h33, 1'b1);
        chk("ptr_wrap_two", {24'd0, dut.r_ptr}, {24'd0, m_ptr});
        check_mem();

        // 3-byte sequential read, then idle clocks in WAIT_STOP
        read_txn(1'b1, 8'h0E, 3, 3);

        // repeated START in the middle of a data byte aborts it
        bus_start();
        send_byte(8'hA0, ack, oe9);
        send_byte(8'h02, ack, oe9);
        m_ptr = 8'h02;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_start();
        bus_stop();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ptr", {24'd0, dut.r_ptr}, 32'h02);
        chk("abort_no_strobe", exp_q.size(), 32'd0);
        check_mem();

        // reset while the slave is driving the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
        m_oe = 1'b0; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        chk("ack_driven_before_rst", {31'd0, dut_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_oe", {31'd0, dut_oe}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_wr_data", {24'd0, wr_data}, 32'd0);
        model_reset();
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

        // reset during the 5th data bit of a write
        bus_start();
        send_byte(8'hA0, ack, oe9);
        send_byte(8'h07, ack, oe9);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        m_oe = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bit5_oe", {31'd0, dut_oe}, 32'd0);
        chk("rst_bit5_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_bit5_ptr", {24'd0, dut.r_ptr}, 32'd0);
        m_oe = 1'b0;
        wait_clk(4);
        check_mem();
        rst_n = 1'b1;
        wait_clk(4);
        chk("rst_bit5_no_strobe", exp_q.size(), 32'd0);

        write_txn(7'h50, 8'h09, 1, 8'h5A, 8'h00, 1'b1);
        check_mem();

        wait_clk(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
